rect_walker: RTL and testbench

- Parametrised rectangle rasteriser for the pong display path.
- On a start request it latches origin, size, colour and mode, then emits one pixel coordinate per accepted cycle.
- Outline mode walks the border clockwise; fill mode scans the rectangle in raster order.
- Feeds the pixel/framebuffer writer through a valid/ready handshake and clips to the playfield.

---
 rtl/rect_walker.sv | 251 +++++++++++++++++++++++++
 tb/tb_rect_walker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rect_walker.sv
// rect_walker: rectangle rasteriser for the pong display path.
//
// When a start is accepted in IDLE, the block latches the origin, size and
// colour. The draw mode is captured by the walking state it enters. After
// that it presents one candidate pixel per cycle on CounterX/CounterY/color.
//   - Outline mode walks the border clockwise: TOP, RIGHT, BOTTOM, LEFT.
//   - Fill mode scans the rectangle in raster order.
// A candidate that lies outside the playfield (X > X_MAX or Y > Y_MAX) is
// clipped. It is shown with pix_valid = 0 and the walker moves past it
// without waiting on pix_ready.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      draw request, honoured only in IDLE
//   mode       0 = outline, 1 = fill
//   x0, y0     rectangle origin
//   w, h       rectangle width / height in pixels
//   color_in   draw colour
//   pix_ready  downstream accepts the current pixel
//   CounterX   pixel X
//   CounterY   pixel Y
//   color      latched colour
//   pix_valid  CounterX/CounterY/color form a valid pixel
//   busy       a rectangle is being walked
//   done       one-cycle pulse after the last pixel
module rect_walker #(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 3,
    parameter int X_MAX   = 105,
    parameter int Y_MAX   = 115
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] CounterX,
    output logic [COORD_W-1:0] CounterY,
    output logic [COLOR_W-1:0] color,
    output logic               pix_valid,
    output logic               busy,
    output logic               done
);

    // One extra bit keeps the end-point sums from wrapping back into view.
    localparam int IW = COORD_W + 1;
    localparam logic [IW-1:0]      ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]      TWO   = {{(IW-2){1'b0}}, 2'b10};
    localparam logic [COORD_W-1:0] ZEROC = {COORD_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TOP    = 3'd1,
        S_RIGHT  = 3'd2,
        S_BOTTOM = 3'd3,
        S_LEFT   = 3'd4,
        S_FILL   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              state_r, state_nx;
    logic [IW-1:0]       cx_r, cy_r, cx_nx, cy_nx;
    logic [IW-1:0]       x0_r, y0_r, w_r, h_r;
    logic [IW-1:0]       xe_s, ye_s;
    logic [COLOR_W-1:0]  color_r;
    logic                pix_valid_r, busy_r, done_r;
    logic                advance_s, walk_nx_s, accept_s;

    // A candidate outside the playfield is never offered downstream.
    function automatic logic is_clipped(input logic [IW-1:0] x, input logic [IW-1:0] y);
        return (x > IW'(X_MAX)) || (y > IW'(Y_MAX));
    endfunction

    // Far edges of the latched rectangle (only used once w, h >= 1).
    assign xe_s = x0_r + w_r - ONE;
    assign ye_s = y0_r + h_r - ONE;

    // Step when the current pixel transfers, or at once when it was clipped.
    assign advance_s = !pix_valid_r || pix_ready;
    assign accept_s  = (state_r == S_IDLE) && start;
    assign walk_nx_s = (state_nx == S_TOP) || (state_nx == S_RIGHT) || (state_nx == S_BOTTOM) ||
                       (state_nx == S_LEFT) || (state_nx == S_FILL);

    // Next walker state and candidate coordinate.
    always_comb begin
        state_nx = state_r;
        cx_nx    = cx_r;
        cy_nx    = cy_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    cx_nx = {1'b0, x0};
                    cy_nx = {1'b0, y0};
                    if ((w == ZEROC) || (h == ZEROC)) begin
                        state_nx = S_DONE;
                    end else if (mode) begin
                        state_nx = S_FILL;
                    end else begin
                        state_nx = S_TOP;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_TOP: begin
                if (advance_s) begin
                    if (cx_r == xe_s) begin
                        // A one-row rectangle is fully drawn by its top edge.
                        if (h_r == ONE) begin
                            state_nx = S_DONE;
                        end else begin
                            state_nx = S_RIGHT;
                            cx_nx    = xe_s;
                            cy_nx    = y0_r + ONE;
                        end
                    end else begin
                        cx_nx = cx_r + ONE;
                    end
                end else begin
                    state_nx = S_TOP;
                end
            end
            S_RIGHT: begin
                if (advance_s) begin
                    if (cy_r == ye_s) begin
                        // A one-column rectangle has no bottom or left pixels left.
                        if (w_r == ONE) begin
                            state_nx = S_DONE;
                        end else begin
                            state_nx = S_BOTTOM;
                            cx_nx    = xe_s - ONE;
                            cy_nx    = ye_s;
                        end
                    end else begin
                        cy_nx = cy_r + ONE;
                    end
                end else begin
                    state_nx = S_RIGHT;
                end
            end
            S_BOTTOM: begin
                if (advance_s) begin
                    if (cx_r == x0_r) begin
                        // Left edge excludes both corners, so it needs h >= 3.
                        if (h_r > TWO) begin
                            state_nx = S_LEFT;
                            cx_nx    = x0_r;
                            cy_nx    = ye_s - ONE;
                        end else begin
                            state_nx = S_DONE;
                        end
                    end else begin
                        cx_nx = cx_r - ONE;
                    end
                end else begin
                    state_nx = S_BOTTOM;
                end
            end
            S_LEFT: begin
                if (advance_s) begin
                    if (cy_r == (y0_r + ONE)) begin
                        state_nx = S_DONE;
                    end else begin
                        cy_nx = cy_r - ONE;
                    end
                end else begin
                    state_nx = S_LEFT;
                end
            end
            S_FILL: begin
                if (advance_s) begin
                    if (cx_r == xe_s) begin
                        if (cy_r == ye_s) begin
                            state_nx = S_DONE;
                        end else begin
                            cx_nx = x0_r;
                            cy_nx = cy_r + ONE;
                        end
                    end else begin
                        cx_nx = cx_r + ONE;
                    end
                end else begin
                    state_nx = S_FILL;
                end
            end
            S_DONE: begin
                // A start seen here is deliberately dropped.
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, coordinate and registered output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            cx_r        <= {IW{1'b0}};
            cy_r        <= {IW{1'b0}};
            pix_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cx_r        <= cx_nx;
            cy_r        <= cy_nx;
            pix_valid_r <= walk_nx_s && !is_clipped(cx_nx, cy_nx);
            busy_r      <= walk_nx_s;
            done_r      <= (state_nx == S_DONE);
        end
    end

    // Rectangle geometry and colour captured on start acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x0_r    <= {IW{1'b0}};
            y0_r    <= {IW{1'b0}};
            w_r     <= {IW{1'b0}};
            h_r     <= {IW{1'b0}};
            color_r <= {COLOR_W{1'b0}};
        end else if (accept_s) begin
            x0_r    <= {1'b0, x0};
            y0_r    <= {1'b0, y0};
            w_r     <= {1'b0, w};
            h_r     <= {1'b0, h};
            color_r <= color_in;
        end else begin
            x0_r    <= x0_r;
            y0_r    <= y0_r;
            w_r     <= w_r;
            h_r     <= h_r;
            color_r <= color_r;
        end
    end

    assign CounterX  = cx_r[COORD_W-1:0];
    assign CounterY  = cy_r[COORD_W-1:0];
    assign color     = color_r;
    assign pix_valid = pix_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_rect_walker.sv
// Testbench for rect_walker.
// A reference generator turns each draw request into its list of candidate
// pixels, marking which ones fall off the playfield. That list is queued when
// the request is driven. Candidates are popped as the DUT transfers or clips
// them, and each popped candidate is compared with what the DUT shows.
module tb_rect_walker;

    localparam int CW = 8;
    localparam int KW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [CW-1:0] x0, y0, w, h;
    logic [KW-1:0] color_in;
    logic          pix_ready;
    logic [CW-1:0] CounterX, CounterY;
    logic [KW-1:0] color;
    logic          pix_valid, busy, done;

    typedef struct {
        int x;
        int y;
        bit clip;
    } cand_t;

    cand_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_valid_exp;

    rect_walker #(.COORD_W(CW), .COLOR_W(KW), .X_MAX(105), .Y_MAX(115)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .w(w), .h(h), .color_in(color_in),
        .pix_ready(pix_ready),
        .CounterX(CounterX), .CounterY(CounterY), .color(color),
        .pix_valid(pix_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cand(input int x, input int y);
        cand_t c;
        c.x    = x;
        c.y    = y;
        c.clip = (x > 105) || (y > 115);
        if (!c.clip) n_valid_exp++;
        q.push_back(c);
    endtask

    // Reference pixel order, written directly from the segment definitions.
    task automatic gen(input bit md, input int ax, input int ay, input int aw, input int ah);
        q.delete();
        n_valid_exp = 0;
        if (aw == 0 || ah == 0) return;
        if (md) begin
            for (int yy = 0; yy < ah; yy++)
                for (int xx = 0; xx < aw; xx++)
                    push_cand(ax + xx, ay + yy);
        end else begin
            for (int i = 0; i < aw; i++) push_cand(ax + i, ay);
            for (int j = 1; j < ah; j++) push_cand(ax + aw - 1, ay + j);
            if (ah > 1) for (int i = aw - 2; i >= 0; i--) push_cand(ax + i, ay + ah - 1);
            if (aw > 1) for (int j = ah - 2; j >= 1; j--) push_cand(ax, ay + j);
        end
    endtask

    // Drives one request and follows it to the done pulse.
    task automatic run(input bit md, input int ax, input int ay, input int aw, input int ah,
                       input int acol, input int stall_at, input int stall_len,
                       input bit clip_rdy_low, input bit hold_start);
        int    k, xfers, stalls, scnt, ncand;
        bit    rdy;
        cand_t c;
        gen(md, ax, ay, aw, ah);
        ncand = q.size();
        @(posedge clk); #1;
        mode      = md;
        x0        = CW'(ax);
        y0        = CW'(ay);
        w         = CW'(aw);
        h         = CW'(ah);
        color_in  = KW'(acol);
        pix_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        // Request inputs are scrambled so any use after acceptance shows up.
        if (!hold_start) start = 1'b0;
        x0       = CW'($urandom);
        y0       = CW'($urandom);
        w        = CW'($urandom);
        h        = CW'($urandom);
        color_in = KW'($urandom);
        mode     = 1'($urandom);
        k      = 1;
        xfers  = 0;
        stalls = 0;
        scnt   = 0;
        for (int guard = 0; guard < 2000; guard++) begin
            if (hold_start && k == 3) start = 1'b0;
            if (q.size() == 0) begin
                pix_ready = 1'b1;
                @(negedge clk);
                check_eq("done", 32'(done), 32'd1);
                check_eq("done_busy", 32'(busy), 32'd0);
                check_eq("done_valid", 32'(pix_valid), 32'd0);
                check_eq("done_cycle", k, ncand + stalls + 1);
                check_eq("xfers", xfers, n_valid_exp);
                @(posedge clk); #1;
                check_eq("done_pulse", 32'(done), 32'd0);
                return;
            end
            c = q[0];
            if (c.clip) rdy = !clip_rdy_low;
            else if (xfers == stall_at && scnt < stall_len) rdy = 1'b0;
            else rdy = 1'b1;
            pix_ready = rdy;
            @(negedge clk);
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("early_done", 32'(done), 32'd0);
            if (c.clip) begin
                check_eq("clip_valid", 32'(pix_valid), 32'd0);
                void'(q.pop_front());
            end else begin
                check_eq("valid", 32'(pix_valid), 32'd1);
                check_eq("x", 32'(CounterX), c.x);
                check_eq("y", 32'(CounterY), c.y);
                check_eq("color", 32'(color), acol);
                if (rdy) begin
                    void'(q.pop_front());
                    xfers++;
                end else begin
                    scnt++;
                    stalls++;
                end
            end
            @(posedge clk); #1;
            k++;
        end
        check_eq("timeout_left", q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_x"}, 32'(CounterX), 32'd0);
        check_eq({tag, "_y"}, 32'(CounterY), 32'd0);
        check_eq({tag, "_color"}, 32'(color), 32'd0);
        check_eq({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        x0        = '0;
        y0        = '0;
        w         = '0;
        h         = '0;
        color_in  = '0;
        pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle");

        // Full playfield outline: 440 pixels, done on cycle 441.
        run(1'b0, 0, 0, 106, 116, 3, -1, 0, 1'b0, 1'b0);
        // Small fill in raster order.
        run(1'b1, 10, 20, 3, 2, 5, -1, 0, 1'b0, 1'b0);
        // Backpressure on the second pixel for three cycles.
        run(1'b0, 4, 4, 2, 2, 2, 1, 3, 1'b0, 1'b0);
        // Degenerate sizes.
        run(1'b0, 7, 7, 1, 3, 1, -1, 0, 1'b0, 1'b0);
        run(1'b0, 50, 60, 3, 1, 4, -1, 0, 1'b0, 1'b0);
        run(1'b0, 1, 1, 0, 5, 6, -1, 0, 1'b0, 1'b0);
        run(1'b1, 1, 1, 5, 0, 7, -1, 0, 1'b0, 1'b0);
        // Clipping on X, with pix_ready low through the clipped cycles.
        run(1'b0, 104, 0, 4, 2, 3, -1, 0, 1'b1, 1'b0);
        // Fill straddling both playfield edges, with stalls mid-way.
        run(1'b1, 100, 110, 10, 10, 6, 5, 2, 1'b0, 1'b0);
        // Fully off-screen, with sums past the coordinate width.
        run(1'b0, 250, 250, 10, 2, 1, -1, 0, 1'b1, 1'b0);

        // Reset in the middle of the right edge.
        @(posedge clk); #1;
        mode     = 1'b0;
        x0       = 8'd0;
        y0       = 8'd0;
        w        = 8'd5;
        h        = 8'd5;
        color_in = 3'd6;
        pix_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        // Restart, holding start high into the walk to show it is ignored.
        run(1'b0, 3, 3, 4, 3, 5, -1, 0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
